// File: rtl/quest_result_checker.sv
// quest_result_checker
// Self-checking monitor that sits beside the pipelined compare datapath.
// It recomputes the golden flag from the same counter word the datapath
// consumes, delays it by the datapath latency and compares it with the
// datapath's flag. It keeps saturating check/mismatch counts, a sticky error
// and the first failing word.
//
// Word layout on vec: {D, C, B, A} with A = vec[7:0] ... D = vec[31:24].
// Golden flag:        ((A | B) != ((B & C) ^ D)).

module quest_result_checker #(
  parameter int LATENCY = 3,   // cycles from a word on vec to its flag on flag_in (1..8)
  parameter int CNT_W   = 32   // width of the statistics counters
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             vec_valid,
  input  logic [31:0]      vec,
  input  logic             flag_in,
  output logic             expected,
  output logic             check_en,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] checked_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [31:0]      first_err_vec,
  output logic [1:0]       state
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------

  // One delay-line entry: the word, its golden flag and whether it was real.
  typedef struct packed {
    logic        valid;
    logic        gold;
    logic [31:0] vec;
  } stage_t;

  // Encodings are visible on the state port, so they are fixed explicitly.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // nothing seen since reset/clear
    S_FILL  = 2'd1,  // first word is travelling down the delay line
    S_CHECK = 2'd2,  // comparing, no error seen yet
    S_FAIL  = 2'd3   // at least one mismatch seen; still comparing
  } state_t;

  // Fill counter counts clock edges since the word that started FILL.
  // Four bits cover the full legal LATENCY range of 1..8.
  localparam int                FILL_W    = 4;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------

  // clr is a full soft reset: it clears everything rst clears.
  logic              wipe;

  logic              gold;
  stage_t            line_q [LATENCY];
  stage_t            tail;

  state_t            state_q;
  state_t            state_d;
  logic [FILL_W-1:0] fill_cnt_q;
  logic [FILL_W-1:0] fill_cnt_d;

  logic [CNT_W-1:0]  checked_count_q;
  logic [CNT_W-1:0]  mismatch_count_q;
  logic              err_sticky_q;
  logic [31:0]       first_err_vec_q;

  assign wipe = rst | clr;

  // ---------------------------------------------------------------------------
  // Golden model
  // ---------------------------------------------------------------------------

  // Golden flag for the word on vec this cycle; purely combinational.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a value on every
    // path (here trivially, elsewhere via defaults first) so no latch is inferred.
    gold = ((vec[7:0] | vec[15:8]) != ((vec[15:8] & vec[23:16]) ^ vec[31:24]));
  end

  // ---------------------------------------------------------------------------
  // Delay line
  // ---------------------------------------------------------------------------

  // Shift {valid, gold, vec} down the line every cycle; there is no stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // stages sample their neighbour's old value on the same edge.
    if (wipe) begin
      // NOTE: the line is an array of registers, but it is cleared on reset on
      // purpose: words in flight at reset must never reach the comparator.
      for (int k = 0; k < LATENCY; k++) begin
        line_q[k] <= '0;
      end
    end else begin
      line_q[0] <= {vec_valid, gold, vec};
      for (int k = 1; k < LATENCY; k++) begin
        line_q[k] <= line_q[k-1];
      end
    end
  end

  // The tail is the entry that lines up with flag_in this cycle.
  assign tail = line_q[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register and fill counter.
  always_ff @(posedge clk) begin
    if (wipe) begin
      state_q    <= S_IDLE;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Next-state logic. FILL lasts until the first word sits in the tail, so
  // that word is the first one compared.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (vec_valid) begin
          if (LATENCY == 1) begin
            // The word lands directly in the tail on this edge.
            state_d = S_CHECK;
          end else begin
            state_d    = S_FILL;
            fill_cnt_d = FILL_ONE;
          end
        end
      end
      S_FILL: begin
        if (fill_cnt_q == FILL_LAST) begin
          state_d = S_CHECK;
        end else begin
          fill_cnt_d = fill_cnt_q + FILL_ONE;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          state_d = S_FAIL;
        end
      end
      S_FAIL: begin
        // Terminal until rst or clr; comparisons carry on.
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Comparison outputs. flag_in only matters when check_en is high, so an
  // unknown flag during FILL or on bubbles cannot raise mismatch.
  always_comb begin
    check_en = tail.valid && ((state_q == S_CHECK) || (state_q == S_FAIL));
    mismatch = check_en && (flag_in != tail.gold);
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------

  // Saturating counters plus capture of the first failing word.
  always_ff @(posedge clk) begin
    if (wipe) begin
      checked_count_q  <= '0;
      mismatch_count_q <= '0;
      err_sticky_q     <= 1'b0;
      first_err_vec_q  <= '0;
    end else begin
      if (check_en && (checked_count_q != CNT_MAX)) begin
        checked_count_q <= checked_count_q + CNT_ONE;
      end
      if (mismatch && (mismatch_count_q != CNT_MAX)) begin
        mismatch_count_q <= mismatch_count_q + CNT_ONE;
      end
      // Only the first mismatch since reset/clear is recorded.
      if (mismatch && !err_sticky_q) begin
        err_sticky_q    <= 1'b1;
        first_err_vec_q <= tail.vec;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign expected       = tail.gold;
  assign err_sticky     = err_sticky_q;
  assign checked_count  = checked_count_q;
  assign mismatch_count = mismatch_count_q;
  assign first_err_vec  = first_err_vec_q;
  assign state          = state_q;

endmodule

// File: tb/tb_quest_result_checker.sv
// Directed testbench for quest_result_checker. A small flag pipeline stands in
// for the datapath; single words can have their flag inverted to plant errors.
// A second instance with 4-bit counters exercises saturation.

module tb_quest_result_checker;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        vec_valid = 1'b0;
  logic [31:0] vec = '0;
  logic        inj = 1'b0;
  logic        flag_x = 1'b0;
  logic        flag_in;
  logic [LAT-1:0] fl_pipe = '0;

  logic        expected, check_en, mismatch, err_sticky;
  logic [31:0] checked_count, mismatch_count, first_err_vec;
  logic [1:0]  state;

  logic        expected4, check_en4, mismatch4, err_sticky4;
  logic [3:0]  checked_count4, mismatch_count4;
  logic [31:0] first_err_vec4;
  logic [1:0]  state4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quest_result_checker #(.LATENCY(LAT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .vec_valid(vec_valid), .vec(vec),
    .flag_in(flag_in), .expected(expected), .check_en(check_en),
    .mismatch(mismatch), .err_sticky(err_sticky),
    .checked_count(checked_count), .mismatch_count(mismatch_count),
    .first_err_vec(first_err_vec), .state(state)
  );

  quest_result_checker #(.LATENCY(LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .vec_valid(vec_valid), .vec(vec),
    .flag_in(flag_in), .expected(expected4), .check_en(check_en4),
    .mismatch(mismatch4), .err_sticky(err_sticky4),
    .checked_count(checked_count4), .mismatch_count(mismatch_count4),
    .first_err_vec(first_err_vec4), .state(state4)
  );

  // Reference datapath flag for a counter word.
  function automatic logic gold_of(input logic [31:0] v);
    return ((v[7:0] | v[15:8]) != ((v[15:8] & v[23:16]) ^ v[31:24]));
  endfunction

  // Datapath stand-in: flag emerges LAT cycles after its word, optionally inverted.
  always @(posedge clk) fl_pipe <= {fl_pipe[LAT-2:0], gold_of(vec) ^ inj};
  assign flag_in = flag_x ? 1'bx : fl_pipe[LAT-1];

  // Drive one cycle of input, then return 1 time unit after the clock edge.
  task automatic cycle(input logic v_valid, input logic [31:0] v, input logic injv);
    vec_valid = v_valid;
    vec       = v;
    inj       = injv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b0;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (check_en !== 1'b0) begin bad++; $display("FAIL reset_check_en got=%b want=0", check_en); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL reset_mismatch got=%b want=0", mismatch); end
    total++; if (expected !== 1'b0) begin bad++; $display("FAIL reset_expected got=%b want=0", expected); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_sticky); end
    total++; if (checked_count !== 32'd0) begin bad++; $display("FAIL reset_checked got=%0d want=0", checked_count); end
    total++; if (mismatch_count !== 32'd0) begin bad++; $display("FAIL reset_mmcount got=%0d want=0", mismatch_count); end
    total++; if (first_err_vec !== 32'd0) begin bad++; $display("FAIL reset_first got=%h want=0", first_err_vec); end
    rst = 1'b0;
  endtask

  // One zero word; flag_in is X while the word is filling the line.
  task automatic test_single();
    flag_x = 1'b1;
    cycle(1'b1, 32'h0, 1'b0);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL single_fill_state got=%0d want=1", state); end
    total++; if (check_en !== 1'b0) begin bad++; $display("FAIL single_fill_check_en got=%b want=0", check_en); end
    for (int i = 0; i < LAT - 1; i++) begin
      if (i == LAT - 2) flag_x = 1'b0;
      cycle(1'b0, 32'h0, 1'b0);
      if (i < LAT - 2) begin
        total++; if (state !== 2'd1) begin bad++; $display("FAIL single_fill_hold got=%0d want=1", state); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL single_x_flag mismatch got=%b want=0", mismatch); end
      end
    end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL single_check_state got=%0d want=2", state); end
    total++; if (check_en !== 1'b1) begin bad++; $display("FAIL single_check_en got=%b want=1", check_en); end
    total++; if (expected !== 1'b0) begin bad++; $display("FAIL single_expected got=%b want=0", expected); end
    total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL single_mismatch got=%b want=0", mismatch); end
    cycle(1'b0, 32'h0, 1'b0);
    total++; if (check_en !== 1'b0) begin bad++; $display("FAIL single_after_check_en got=%b want=0", check_en); end
    total++; if (checked_count !== 32'd1) begin bad++; $display("FAIL single_checked got=%0d want=1", checked_count); end
  endtask

  // Hand-computed golden values for a few operand patterns, back to back.
  task automatic test_patterns();
    logic [31:0] pw [3];
    logic        pe [3];
    logic [31:0] base;
    int j;
    pw = '{32'h0000_0001, 32'h0100_0000, 32'h0001_0101};
    pe = '{1'b1, 1'b1, 1'b0};
    base = checked_count;
    for (int i = 0; i < 3 + LAT; i++) begin
      cycle(i < 3, (i < 3) ? pw[i] : 32'h0, 1'b0);
      j = i - (LAT - 1);
      if (j >= 0 && j < 3) begin
        total++; if (check_en !== 1'b1) begin bad++; $display("FAIL pattern%0d_check_en got=%b want=1", j, check_en); end
        total++; if (expected !== pe[j]) begin bad++; $display("FAIL pattern%0d_expected got=%b want=%b", j, expected, pe[j]); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL pattern%0d_mismatch got=%b want=0", j, mismatch); end
      end
    end
    total++; if (checked_count - base !== 32'd3) begin bad++; $display("FAIL pattern_checked got=%0d want=3", checked_count - base); end
    total++; if (mismatch_count !== 32'd0) begin bad++; $display("FAIL pattern_mmcount got=%0d want=0", mismatch_count); end
  endtask

  // Counter 0..999 continuously with the datapath stand-in supplying flags.
  task automatic test_counter_run();
    logic [31:0] base;
    int ce;
    base = checked_count;
    ce = 0;
    for (int i = 0; i < 1000 + LAT; i++) begin
      cycle(i < 1000, 32'(i), 1'b0);
      if (check_en === 1'b1) ce++;
    end
    total++; if (checked_count - base !== 32'd1000) begin bad++; $display("FAIL run_checked got=%0d want=1000", checked_count - base); end
    total++; if (ce != 1000) begin bad++; $display("FAIL run_check_en_cycles got=%0d want=1000", ce); end
    total++; if (mismatch_count !== 32'd0) begin bad++; $display("FAIL run_mmcount got=%0d want=0", mismatch_count); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL run_err got=%b want=0", err_sticky); end
  endtask

  // Inverted flags for words 5 and 9 only.
  task automatic test_error_inject();
    logic [31:0] base;
    int j, seen;
    base = checked_count;
    seen = 0;
    for (int i = 0; i < 13 + LAT; i++) begin
      cycle(i < 13, 32'(i), (i == 5) || (i == 9));
      j = i - (LAT - 1);
      if (mismatch === 1'b1) seen++;
      if (j == 5) begin
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL inject5_pulse got=%b want=1", mismatch); end
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL inject5_err_early got=%b want=0", err_sticky); end
        total++; if (mismatch_count !== 32'd0) begin bad++; $display("FAIL inject5_mmcount_early got=%0d want=0", mismatch_count); end
      end
      if (j == 6) begin
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL inject5_err got=%b want=1", err_sticky); end
        total++; if (first_err_vec !== 32'h5) begin bad++; $display("FAIL inject5_first got=%h want=00000005", first_err_vec); end
        total++; if (mismatch_count !== 32'd1) begin bad++; $display("FAIL inject5_mmcount got=%0d want=1", mismatch_count); end
        total++; if (state !== 2'd3) begin bad++; $display("FAIL inject5_state got=%0d want=3", state); end
      end
      if (j == 9) begin
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL inject9_pulse got=%b want=1", mismatch); end
      end
    end
    total++; if (seen != 2) begin bad++; $display("FAIL inject_pulses got=%0d want=2", seen); end
    total++; if (first_err_vec !== 32'h5) begin bad++; $display("FAIL inject_first_kept got=%h want=00000005", first_err_vec); end
    total++; if (mismatch_count !== 32'd2) begin bad++; $display("FAIL inject_mmcount got=%0d want=2", mismatch_count); end
    total++; if (checked_count - base !== 32'd13) begin bad++; $display("FAIL inject_checked got=%0d want=13", checked_count - base); end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL inject_state got=%0d want=3", state); end
  endtask

  // Valid/bubble alternation while in FAIL: only real words are counted.
  task automatic test_bubbles();
    logic [31:0] base;
    int j, ce;
    base = checked_count;
    ce = 0;
    for (int i = 0; i < 10 + LAT; i++) begin
      cycle((i < 10) && (i % 2 == 0), 32'(100 + i), 1'b0);
      if (check_en === 1'b1) ce++;
      j = i - (LAT - 1);
      if (j >= 0 && j < 10) begin
        total++; if (check_en !== (j % 2 == 0)) begin bad++; $display("FAIL bubble%0d_check_en got=%b want=%b", j, check_en, (j % 2 == 0)); end
      end
    end
    total++; if (checked_count - base !== 32'd5) begin bad++; $display("FAIL bubble_checked got=%0d want=5", checked_count - base); end
    total++; if (ce != 5) begin bad++; $display("FAIL bubble_cycles got=%0d want=5", ce); end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL bubble_state got=%0d want=3", state); end
    total++; if (mismatch_count !== 32'd2) begin bad++; $display("FAIL bubble_mmcount got=%0d want=2", mismatch_count); end
  endtask

  // rst with words in flight: none of them may be checked; checking resumes later.
  task automatic test_rst_inflight();
    int ce;
    cycle(1'b1, 32'h20, 1'b0);
    cycle(1'b1, 32'h21, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 32'h22, 1'b0);
    rst = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_sticky); end
    total++; if (first_err_vec !== 32'd0) begin bad++; $display("FAIL rst_first got=%h want=0", first_err_vec); end
    ce = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (check_en === 1'b1) ce++;
    end
    total++; if (ce != 0) begin bad++; $display("FAIL rst_inflight_checks got=%0d want=0", ce); end
    total++; if (checked_count !== 32'd0) begin bad++; $display("FAIL rst_checked got=%0d want=0", checked_count); end
    cycle(1'b1, 32'h30, 1'b0);
    for (int i = 0; i < LAT - 1; i++) cycle(1'b0, 32'h0, 1'b0);
    total++; if (check_en !== 1'b1) begin bad++; $display("FAIL rst_resume_check_en got=%b want=1", check_en); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL rst_resume_state got=%0d want=2", state); end
    cycle(1'b0, 32'h0, 1'b0);
    total++; if (checked_count !== 32'd1) begin bad++; $display("FAIL rst_resume_checked got=%0d want=1", checked_count); end
  endtask

  // clr out of FAIL, then counter saturation on the 4-bit instance, then rst+clr.
  task automatic test_clr_and_saturate();
    cycle(1'b1, 32'h7, 1'b1);
    for (int i = 0; i < LAT; i++) cycle(1'b0, 32'h0, 1'b0);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL clr_pre_state got=%0d want=3", state); end
    clr = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    clr = 1'b0;
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", err_sticky); end
    total++; if (checked_count !== 32'd0) begin bad++; $display("FAIL clr_checked got=%0d want=0", checked_count); end
    total++; if (mismatch_count !== 32'd0) begin bad++; $display("FAIL clr_mmcount got=%0d want=0", mismatch_count); end
    total++; if (first_err_vec !== 32'd0) begin bad++; $display("FAIL clr_first got=%h want=0", first_err_vec); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL clr_state got=%0d want=0", state); end
    total++; if (checked_count4 !== 4'd0) begin bad++; $display("FAIL clr_checked4 got=%0d want=0", checked_count4); end
    for (int i = 0; i < 20 + LAT; i++) cycle(i < 20, 32'(200 + i), 1'b0);
    total++; if (checked_count !== 32'd20) begin bad++; $display("FAIL sat_checked32 got=%0d want=20", checked_count); end
    total++; if (checked_count4 !== 4'd15) begin bad++; $display("FAIL sat_checked4 got=%0d want=15", checked_count4); end
    total++; if (mismatch_count4 !== 4'd0) begin bad++; $display("FAIL sat_mmcount4 got=%0d want=0", mismatch_count4); end
    rst = 1'b1;
    clr = 1'b1;
    cycle(1'b1, 32'h1, 1'b0);
    rst = 1'b0;
    clr = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rstclr_state got=%0d want=0", state); end
    total++; if (checked_count !== 32'd0) begin bad++; $display("FAIL rstclr_checked got=%0d want=0", checked_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_patterns();
    test_counter_run();
    test_error_inject();
    test_bubbles();
    test_rst_inflight();
    test_clr_and_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
